alu_div_seq: RTL and testbench
==============================

Name: alu_div_seq

Overview:
- Multi-cycle restoring integer divider; the inverse companion to the ALU's add/subtract datapath. It produces quotient and remainder from dividend and divisor.
- One quotient bit per cycle, using a WIDTH+1-bit trial subtract (add of inverted divisor with carry-in 1).
- Sits beside the ALU in the execute stage; the control unit starts it and stalls until done.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a divide; sampled only in IDLE
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while a divide is in progress (RUN)
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  result quotient, held until next accepted start
- remainder  output  WIDTH  result remainder, held until next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; the iteration counter is cleared.
- Reset mid-operation aborts the divide. No done pulse is produced and the outputs are zeroed.
- States:
  - IDLE: start=1 captures the operands and clears div_by_zero. A nonzero divisor goes to RUN. A zero divisor goes to ZERO.
  - RUN: busy=1 for exactly WIDTH cycles. The counter runs WIDTH-1 down to 0. The last iteration goes to FIN.
  - ZERO: one cycle. Writes quotient = all ones and remainder = dividend, sets div_by_zero=1, pulses done, then returns to IDLE.
  - FIN: one cycle. Pulses done, writes quotient/remainder, returns to IDLE. busy=0 in FIN.
- Iteration:
  - partial remainder P (WIDTH+1 bits) and shift register Q are used.
  - Each cycle: P = {P[WIDTH-1:0], Q[WIDTH-1]}, and Q is shifted left.
  - trial = P - {0,D}. If the trial carry-out is 1 (no borrow), P = trial and Q[0]=1; else Q[0]=0.
- Latency:
  - Start accepted in cycle T; busy is high for cycles T+1..T+WIDTH; done is high in cycle T+WIDTH+1.
  - For divide-by-zero, done is high in cycle T+1.
- Handshake:
  - start while busy, or in FIN/ZERO, is ignored; no queueing.
  - start in the same cycle as rst is ignored.
  - start is allowed in the IDLE cycle right after done (back-to-back).
- Operands are captured at start. Input changes during RUN have no effect.
- Results are unsigned by default. quotient*divisor + remainder = dividend, with remainder < divisor.

Optional Feature:
- Macro: ALU_DIV_SIGNED_EN.
- When defined:
  - Adds input port signed_op (1 bit, captured at start).
  - When signed_op=1, operand magnitudes are taken at capture.
  - At FIN: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Overflow case: most-negative / -1 gives quotient = most-negative, remainder = 0, with no flag.
  - Signed divide-by-zero gives quotient = all ones, remainder = dividend.
  - Latency is identical to the unsigned case.
- When undefined: no signed_op port; all operations are unsigned.

Test Plan:
- Reset, then start with dividend=100, divisor=7 at cycle T -> busy high T+1..T+32; done at T+33; quotient=14, remainder=2; div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then start back-to-back in the cycle after done with 5/10 -> quotient=0, remainder=5.
- dividend=0x1234, divisor=0 -> done at T+1; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- start 100/7, then pulse start with 9/3 at T+10, and change the operand inputs -> ignored; result is still 14 r 2 at T+33.
- start 100/7, assert rst at T+15 -> next cycle busy=0, quotient=0, remainder=0; no done pulse follows.
- With ALU_DIV_SIGNED_EN and signed_op=1:
  - -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, unsigned by default.
// Define ALU_DIV_SIGNED_EN to add the signed_op port for two's-complement divides.
module alu_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_FIN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic             neg_q, neg_r;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             cap_neg_q, cap_neg_r;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH-1:0] sub_r;
    logic             sub_c;
    logic             no_borrow;
    logic [WIDTH-1:0] p_nx, q_nx;
    logic [WIDTH-1:0] q_res, r_res;

`ifdef ALU_DIV_SIGNED_EN
    always_comb begin
        a_mag     = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag     = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        cap_neg_q = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        cap_neg_r = signed_op & dividend[WIDTH-1];
    end
`else
    assign a_mag     = dividend;
    assign b_mag     = divisor;
    assign cap_neg_q = 1'b0;
    assign cap_neg_r = 1'b0;
`endif

    // WIDTH+1-bit trial P - {0,D}: a set top bit of the shifted remainder always
    // clears the divisor, otherwise the low WIDTH-bit subtract decides the carry.
    assign p_sh      = {p, q[WIDTH-1]};
    assign {sub_c, sub_r} = {1'b0, p_sh[WIDTH-1:0]} + {1'b0, ~d} + {{WIDTH{1'b0}}, 1'b1};
    assign no_borrow = p_sh[WIDTH] | sub_c;
    assign p_nx      = no_borrow ? sub_r : p_sh[WIDTH-1:0];
    assign q_nx      = {q[WIDTH-2:0], no_borrow};
    assign q_res     = neg_q ? -q_nx : q_nx;
    assign r_res     = neg_r ? -p_nx : p_nx;

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = (divisor == '0) ? S_ZERO : S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = S_FIN;
            end
            S_ZERO: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (start) begin
                    cnt         <= CW'(WIDTH - 1);
                    p           <= '0;
                    q           <= a_mag;
                    d           <= b_mag;
                    neg_q       <= cap_neg_q;
                    neg_r       <= cap_neg_r;
                    div_by_zero <= 1'b0;
                    // Results must be visible in the single ZERO cycle, so write them now.
                    if (divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end
                end
                S_RUN: begin
                    p <= p_nx;
                    q <= q_nx;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        quotient  <= q_res;
                        remainder <= r_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: directed cases with literal expectations plus random
// traffic, all checked every cycle against a cycle-count/arithmetic model.
module tb_alu_div_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
`ifdef ALU_DIV_SIGNED_EN
    logic         signed_op = 1'b0;
`endif
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0, bad = 0, cyc = 0, t_acc = 0, n_done = 0, lat = 0;
    bit chk_en = 1'b0;

    // model: m_k = cycles since accepted start (0 idle, W+1 the done cycle)
    int           m_k = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_z = 1'b0, m_sg = 1'b0;

    always #5 clk = ~clk;

    alu_div_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef ALU_DIV_SIGNED_EN
        .signed_op  (signed_op),
`endif
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = W'(lq);
            r  = W'(lr);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_sg = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
        m_sg = signed_op;
`endif
        if (rst) begin
            m_k = 0; m_q = '0; m_r = '0; m_z = 1'b0;
        end else if (m_k == 0) begin
            if (start) begin
                if (divisor == '0) begin
                    m_k = W + 1; m_q = '1; m_r = dividend; m_z = 1'b1;
                end else begin
                    m_k = 1; m_z = 1'b0;
                    ref_div(dividend, divisor, m_sg, p_q, p_r);
                end
            end
        end else if (m_k == W + 1) begin
            m_k = 0;
        end else begin
            m_k++;
            if (m_k == W + 1) begin
                m_q = p_q; m_r = p_r;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", W'(busy), W'(m_k >= 1 && m_k <= W));
            chk("done", W'(done), W'(m_k == W + 1));
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", W'(div_by_zero), W'(m_z));
        end
        if (done === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        t_acc    = cyc;
        tick();
        start = 1'b0;
    endtask

    // returns latency from the accepting cycle, then steps into the following idle cycle
    task automatic wait_done(input string name, output int l);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, W'(done), W'(1));
        l = cyc - t_acc;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_q", quotient, 32'h0);
        chk("rst_r", remainder, 32'h0);
        chk("rst_dbz", W'(div_by_zero), W'(0));
        rst = 1'b0;
        tick();

        do_start(32'd100, 32'd7);
        chk("busy_first", W'(busy), W'(1));
        wait_done("d100_7", lat);
        chk("lat_100_7", W'(lat), W'(33));
        chk("q_100_7", quotient, 32'd14);
        chk("r_100_7", remainder, 32'd2);
        chk("dbz_100_7", W'(div_by_zero), W'(0));

        do_start(32'hFFFF_FFFF, 32'd1);
        wait_done("dmax_1", lat);
        chk("q_max_1", quotient, 32'hFFFF_FFFF);
        chk("r_max_1", remainder, 32'h0);
        do_start(32'd5, 32'd10);          // idle cycle right after done
        wait_done("d5_10", lat);
        chk("lat_b2b", W'(lat), W'(33));
        chk("q_5_10", quotient, 32'd0);
        chk("r_5_10", remainder, 32'd5);

        do_start(32'h1234, 32'd0);
        wait_done("dzero", lat);
        chk("lat_zero", W'(lat), W'(1));
        chk("q_zero", quotient, 32'hFFFF_FFFF);
        chk("r_zero", remainder, 32'h1234);
        chk("dbz_zero", W'(div_by_zero), W'(1));

        do_start(32'd100, 32'd7);
        repeat (9) tick();
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignored_start", lat);
        chk("lat_ignored", W'(lat), W'(33));
        chk("q_ignored", quotient, 32'd14);
        chk("r_ignored", remainder, 32'd2);

        do_start(32'd100, 32'd7);
        repeat (14) tick();
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_q", quotient, 32'h0);
        chk("abort_r", remainder, 32'h0);
        n_done = 0;
        repeat (40) tick();
        chk("abort_no_done", W'(n_done), W'(0));

`ifdef ALU_DIV_SIGNED_EN
        signed_op = 1'b1;
        do_start(32'hFFFF_FFF9, 32'd2);
        wait_done("s_m7_2", lat);
        chk("lat_signed", W'(lat), W'(33));
        chk("q_m7_2", quotient, 32'hFFFF_FFFD);
        chk("r_m7_2", remainder, 32'hFFFF_FFFF);
        do_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("s_ovf", lat);
        chk("q_ovf", quotient, 32'h8000_0000);
        chk("r_ovf", remainder, 32'h0);
        signed_op = 1'b0;
`endif

        repeat (4000) begin
            start    = ($urandom_range(0, 3) == 0);
            dividend = $urandom;
            case ($urandom_range(0, 5))
                0:       divisor = '0;
                1:       divisor = W'($urandom_range(1, 15));
                2:       divisor = dividend;
                3:       divisor = $urandom >> $urandom_range(0, 31);
                default: divisor = $urandom;
            endcase
`ifdef ALU_DIV_SIGNED_EN
            signed_op = 1'($urandom_range(0, 1));
`endif
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
